// File: rtl/crc_pkg.sv
// Shared types and defaults for the CRC/LFSR engine.
package crc_pkg;

   typedef enum logic [1:0] {
      MODE_BIT  = 2'd0,
      MODE_WORD = 2'd1,
      MODE_LFSR = 2'd2,
      MODE_HOLD = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam logic [7:0] CRC8_POLY = 8'h31;
   localparam logic [7:0] CRC8_INIT = 8'hFF;

   // Bit-counter width that stays legal for a single-bit word.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Single Galois CRC/LFSR step: shift left, fold in POLY when the
// outgoing MSB differs from the input bit.
module crc_lfsr_step
   import crc_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC8_POLY)
) (
   input  logic [WIDTH-1:0] s,
   input  logic             d,
   output logic [WIDTH-1:0] s_next_c
);

   logic fb;

   assign fb       = s[WIDTH-1] ^ d;
   assign s_next_c = {s[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_lfsr_engine.sv
// Parametrised CRC/LFSR engine: bit-serial, word-serial (MSB first) and
// free-running LFSR modes sharing one step datapath.
module crc_lfsr_engine
   import crc_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] POLY    = WIDTH'(CRC8_POLY),
   parameter logic [WIDTH-1:0] INIT    = '1,
   parameter logic [WIDTH-1:0] XOR_OUT = '0,
   parameter logic [WIDTH-1:0] RESIDUE = '0,
   parameter int unsigned      DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [WIDTH-1:0]  crc_out,
   output logic              done,
   output logic              match
);

   localparam int unsigned CNT_W = cnt_width(DATA_W);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [WIDTH-1:0]    crc_q, crc_d;
   logic                done_q, done_d;
   logic [WIDTH-1:0]    step_s;
   logic                step_bit;
   logic                accept;
   mode_e               mode_i;

   assign mode_i   = mode_e'(mode);
   assign in_ready = (state_q == ST_IDLE) && (mode_i != MODE_HOLD) && !clear;
   assign accept   = in_ready && in_valid;

   // Input bit for the shared step: latched word MSB while shifting.
   always_comb begin
      step_bit = 1'b0;
      if (state_q == ST_SHIFT) begin
         step_bit = data_q[DATA_W-1];
      end else if (mode_i == MODE_BIT) begin
         step_bit = in_data[0];
      end
   end

   crc_lfsr_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .s        (crc_q),
      .d        (step_bit),
      .s_next_c (step_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         crc_q   <= INIT;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         crc_q   <= crc_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; clear overrides everything, including a word in flight.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      crc_d   = crc_q;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               unique case (mode_i)
                  MODE_BIT: begin
                     crc_d  = step_s;
                     done_d = 1'b1;
                  end
                  MODE_WORD: begin
                     data_d  = in_data;
                     cnt_d   = '0;
                     state_d = ST_SHIFT;
                  end
                  MODE_LFSR: crc_d = step_s;
                  default: ;
               endcase
            end
         end
         ST_SHIFT: begin
            crc_d  = step_s;
            data_d = data_q << 1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (clear) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         crc_d   = INIT;
         done_d  = 1'b0;
      end
   end

   assign done    = done_q;
   assign crc_out = crc_q ^ XOR_OUT;
   assign match   = (crc_q == RESIDUE);

endmodule

// File: doc/crc_lfsr_engine.md
# crc_lfsr_engine

Parametrised CRC/LFSR engine, the successor to the fixed 8-bit serial CRC shift-register tiles. It generalises register width, polynomial, init value and output XOR. It adds a word-serial mode with a valid/ready handshake, a free-running LFSR mode, a completion pulse and a residue check. It sits between a tile's input pins and its output bus, wrapped by the tile top.

## Interface

Parameters:
- WIDTH, 8: CRC/LFSR register width, 2..32.
- POLY, 8'h31: Galois tap mask, WIDTH bits; bit 0 must be 1.
- INIT, all ones: register value after reset or clear.
- XOR_OUT, 0: mask applied to crc_out.
- RESIDUE, 0: value of the raw register that asserts match.
- DATA_W, 8: word width in WORD mode, 1..16.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous re-init of the register to INIT; aborts any word in flight.
- mode  in  2  0 BIT, 1 WORD, 2 LFSR, 3 HOLD.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- in_data  in  DATA_W  data; BIT mode uses bit 0 only.
- crc_out  out  WIDTH  register XOR XOR_OUT.
- done  out  1  one-cycle pulse after a BIT or WORD beat has fully updated the register.
- match  out  1  raw register equals RESIDUE.

## Operation

- Step rule, with s the register and d the input bit:
  - fb = s[WIDTH-1] ^ d.
  - s' = (s << 1) ^ (fb ? POLY : 0), truncated to WIDTH.
- FSM states:
  - IDLE: in_ready = (mode != HOLD) && !clear.
  - SHIFT: in_ready = 0; bit counter runs 0..DATA_W-1.
- BIT mode, in IDLE with an accepted beat: one step with d = in_data[0] at the same edge; done is 1 the next cycle.
- WORD mode:
  - On accept, latch in_data and mode, go to SHIFT.
  - Each SHIFT cycle steps one bit, MSB first (in_data[DATA_W-1] first).
  - After DATA_W steps, return to IDLE and pulse done.
- LFSR mode: every cycle with in_valid=1 in IDLE, one step with d = 0. done is never pulsed.
- HOLD mode: register frozen; in_ready = 0.
- mode changes during SHIFT are ignored; the latched mode is used until return to IDLE.
- clear has priority over all other activity:
  - register set to INIT, FSM goes to IDLE, bit counter zeroed.
  - no done for the aborted word; done is forced to 0 in the following cycle.
- Beats with in_valid while in_ready = 0 are ignored and not queued.

## Timing

- Reset values:
  - register = INIT, FSM = IDLE, done = 0.
  - crc_out = INIT ^ XOR_OUT.
  - match = (INIT == RESIDUE).
  - in_ready follows mode.
- BIT latency: accept at edge t; crc_out updated after t; done high during cycle t+1. Throughput is 1 bit/cycle (done pulses on consecutive cycles).
- WORD latency: accept at edge t0; steps at edges t1..tDATA_W; crc_out final after tDATA_W; done and in_ready high in the following cycle. Back-to-back throughput is 1 word per DATA_W+1 cycles.
- crc_out and match are combinational from the register; no extra delay.
- Reset asserted mid-word: immediate return to the reset values; no done.

## Structure

- Package crc_pkg holds:
  - mode enum (MODE_BIT, MODE_WORD, MODE_LFSR, MODE_HOLD);
  - FSM state enum (ST_IDLE, ST_SHIFT);
  - default constants CRC8_POLY = 8'h31 and CRC8_INIT = 8'hFF.
- Sub-module crc_lfsr_step: combinational single-step (s, d, POLY) -> s'. It is shared by all modes and reused by the bench reference model.

## Test plan

- Reset, defaults: crc_out = 8'hFF, match = 0, in_ready = 1 (mode BIT), done = 0.
- BIT mode, one beat: from 8'hFF, in_data[0] = 0 -> crc_out 8'hCF with done next cycle. From 8'hFF, in_data[0] = 1 -> 8'hFE.
- WORD mode, ASCII "123456789" (9 beats, back-to-back on in_ready):
  - final crc_out = 8'hF7;
  - each word takes 9 cycles;
  - exactly 9 done pulses.
- Residue check: append word 8'hF7 after the sequence above -> raw register 8'h00, match = 1.
- LFSR mode, in_valid held high from 8'hFF -> 8'hCF, 8'hAF, ... on successive cycles; done stays 0. HOLD mode freezes the value.
- Abort cases:
  - clear asserted at step 4 of a WORD -> crc_out = 8'hFF next cycle, IDLE, no done.
  - rst_n pulsed low mid-word -> same result, asynchronously.
  - in_valid during SHIFT -> ignored.
